multicycle_ctrl_fsm: RTL and testbench

- Main control state machine for the multicycle RV32I core.
- Sequences the single shared ALU, the memory port, the register-file write and the PC/IR enables across states, one instruction at a time.
- Drives the 3-bit instruction-type code consumed by the ALU decoder. Retires one instruction per pass back to FETCH.

---
 rtl/multicycle_ctrl_fsm.sv | 204 ++++++++++++++++++++
 tb/tb_multicycle_ctrl_fsm.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl_fsm.sv
// multicycle_ctrl_fsm: main control FSM of the multicycle RV32I core.
// Sequences the shared ALU, the memory port, the register-file write and the
// PC/IR enables state by state, and retires one instruction per pass through
// FETCH.
// Optional build macro MEM_WAIT_EN: when defined, FETCH, MEMREAD and MEMWRITE
// hold until mem_ready=1. When it is undefined, mem_ready is ignored.
// Ports:
//   clk, rst           rising-edge clock, synchronous active-high reset
//   op                 opcode from the instruction register
//   zero               ALU zero flag (branch decision)
//   mem_ready          memory handshake (MEM_WAIT_EN builds only)
//   pc_write, ir_write PC and IR/OldPC load enables
//   adr_src            memory address select: 0=PC, 1=result bus
//   mem_write          memory write strobe
//   result_src         00=ALUOut, 01=Data, 10=ALU result
//   alu_src_a/b        ALU operand selects
//   alu_op             instruction-type code for the ALU decoder
//   reg_write          register-file write enable
//   instr_done         pulse in the final state of each instruction
//   illegal_op         pulse on an undecodable opcode
//   retired            count of completed instructions (wraps silently)
module multicycle_ctrl_fsm #(
    parameter int OP_WIDTH    = 7,
    parameter int ALUOP_WIDTH = 3,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [OP_WIDTH-1:0]    op,
    input  logic                   zero,
    input  logic                   mem_ready,
    output logic                   pc_write,
    output logic                   adr_src,
    output logic                   mem_write,
    output logic                   ir_write,
    output logic [1:0]             result_src,
    output logic [1:0]             alu_src_a,
    output logic [1:0]             alu_src_b,
    output logic [ALUOP_WIDTH-1:0] alu_op,
    output logic                   reg_write,
    output logic                   instr_done,
    output logic                   illegal_op,
    output logic [CNT_WIDTH-1:0]   retired
);
    localparam logic [OP_WIDTH-1:0] OP_LOAD  = 7'b0000011;
    localparam logic [OP_WIDTH-1:0] OP_STORE = 7'b0100011;
    localparam logic [OP_WIDTH-1:0] OP_R     = 7'b0110011;
    localparam logic [OP_WIDTH-1:0] OP_I     = 7'b0010011;
    localparam logic [OP_WIDTH-1:0] OP_BEQ   = 7'b1100011;
    localparam logic [OP_WIDTH-1:0] OP_JAL   = 7'b1101111;
    localparam logic [OP_WIDTH-1:0] OP_JALR  = 7'b1100111;
    localparam logic [OP_WIDTH-1:0] OP_LUI   = 7'b0110111;
    localparam logic [OP_WIDTH-1:0] OP_AUIPC = 7'b0010111;

    localparam logic [ALUOP_WIDTH-1:0] T_ALU   = 3'b000;
    localparam logic [ALUOP_WIDTH-1:0] T_ADD   = 3'b001;
    localparam logic [ALUOP_WIDTH-1:0] T_STORE = 3'b010;
    localparam logic [ALUOP_WIDTH-1:0] T_BR    = 3'b011;
    localparam logic [ALUOP_WIDTH-1:0] T_AUIPC = 3'b100;
    localparam logic [ALUOP_WIDTH-1:0] T_LUI   = 3'b101;
    localparam logic [ALUOP_WIDTH-1:0] T_JALR  = 3'b110;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI,
        LUI, AUIPC, ALUWB, BEQ, JAL, JALR_ADR, JALR
    } state_t;

    state_t state, next_state;
    logic   ready;

`ifdef MEM_WAIT_EN
    assign ready = mem_ready;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = mem_ready;
    assign ready = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= FETCH;
            retired <= '0;
        end else begin
            state <= next_state;
            if (instr_done)
                retired <= retired + CNT_WIDTH'(1);
        end
    end

    always_comb begin
        next_state = state;
        pc_write   = 1'b0;
        adr_src    = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        result_src = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = T_ALU;
        reg_write  = 1'b0;
        instr_done = 1'b0;
        illegal_op = 1'b0;
        case (state)
            FETCH: begin
                ir_write   = ready;
                pc_write   = ready;
                alu_src_b  = 2'b10;
                alu_op     = T_ADD;
                result_src = 2'b10;
                next_state = ready ? DECODE : FETCH;
            end
            DECODE: begin
                // Precompute branch/JAL target (OldPC + imm) into ALUOut.
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                alu_op    = T_ADD;
                case (op)
                    OP_LOAD, OP_STORE: next_state = MEMADR;
                    OP_R:              next_state = EXECUTER;
                    OP_I:              next_state = EXECUTEI;
                    OP_BEQ:            next_state = BEQ;
                    OP_JAL:            next_state = JAL;
                    OP_JALR:           next_state = JALR_ADR;
                    OP_LUI:            next_state = LUI;
                    OP_AUIPC:          next_state = AUIPC;
                    default: begin
                        next_state = FETCH;
                        illegal_op = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b01;
                alu_op     = (op == OP_STORE) ? T_STORE : T_ADD;
                next_state = (op == OP_STORE) ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                adr_src    = 1'b1;
                next_state = ready ? MEMWB : MEMREAD;
            end
            MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                instr_done = 1'b1;
                next_state = FETCH;
            end
            MEMWRITE: begin
                // Strobe held for the whole wait; retire only on acceptance.
                adr_src    = 1'b1;
                mem_write  = 1'b1;
                instr_done = ready;
                next_state = ready ? FETCH : MEMWRITE;
            end
            EXECUTER: begin
                alu_src_a  = 2'b10;
                next_state = ALUWB;
            end
            EXECUTEI: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b01;
                next_state = ALUWB;
            end
            LUI: begin
                alu_src_b  = 2'b01;
                alu_op     = T_LUI;
                next_state = ALUWB;
            end
            AUIPC: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b01;
                alu_op     = T_AUIPC;
                next_state = ALUWB;
            end
            ALUWB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                next_state = FETCH;
            end
            BEQ: begin
                alu_src_a  = 2'b10;
                alu_op     = T_BR;
                pc_write   = zero;
                instr_done = 1'b1;
                next_state = FETCH;
            end
            JAL, JALR: begin
                // Load target from ALUOut into PC while OldPC+4 is formed.
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                alu_op     = T_ADD;
                pc_write   = 1'b1;
                next_state = ALUWB;
            end
            JALR_ADR: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b01;
                alu_op     = T_JALR;
                next_state = JALR;
            end
            default: next_state = FETCH;
        endcase
    end
endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// tb_multicycle_ctrl_fsm: random-instruction bench for multicycle_ctrl_fsm.
module tb_multicycle_ctrl_fsm;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [6:0]    op = 7'b0110011;
    logic          zero = 1'b0;
    logic          mem_ready = 1'b1;
    logic          pc_write, adr_src, mem_write, ir_write, reg_write;
    logic          instr_done, illegal_op;
    logic [1:0]    result_src, alu_src_a, alu_src_b;
    logic [2:0]    alu_op;
    logic [CW-1:0] retired;

    int checks = 0;
    int errors = 0;

    multicycle_ctrl_fsm #(.CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .op(op), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write),
        .ir_write(ir_write), .result_src(result_src), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_write(reg_write),
        .instr_done(instr_done), .illegal_op(illegal_op), .retired(retired)
    );

    always #5 clk = ~clk;

`ifdef MEM_WAIT_EN
    localparam bit WAIT_EN = 1'b1;
`else
    localparam bit WAIT_EN = 1'b0;
`endif

    // Steps of an instruction, as listed in the control table.
    typedef enum int {
        S_FETCH, S_DEC, S_DEC_ILL, S_ADR_L, S_ADR_S, S_RD, S_LWB, S_WR,
        S_EXR, S_EXI, S_LUI, S_AUIPC, S_WB, S_BEQ, S_JAL, S_JADR, S_JALR
    } step_t;

    step_t plan[$];
    int    model_ret = 0;

    // Packed observable bundle:
    // {pc_write, adr_src, mem_write, ir_write, result_src, a, b, alu_op, reg_write, instr_done, illegal_op}
    function automatic logic [15:0] v(bit pcw, bit adr, bit mw, bit irw, logic [1:0] rs,
                                      logic [1:0] a, logic [1:0] b, logic [2:0] aop,
                                      bit rw, bit done, bit ill);
        return {pcw, adr, mw, irw, rs, a, b, aop, rw, done, ill};
    endfunction

    function automatic logic [15:0] expect_out(step_t s, bit z, bit rdy);
        case (s)
            S_FETCH:   return v(rdy, 0, 0, rdy, 2'b10, 2'b00, 2'b10, 3'b001, 0, 0, 0);
            S_DEC:     return v(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b001, 0, 0, 0);
            S_DEC_ILL: return v(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b001, 0, 0, 1);
            S_ADR_L:   return v(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b001, 0, 0, 0);
            S_ADR_S:   return v(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b010, 0, 0, 0);
            S_RD:      return v(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0, 0);
            S_LWB:     return v(0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 3'b000, 1, 1, 0);
            S_WR:      return v(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0, rdy, 0);
            S_EXR:     return v(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b000, 0, 0, 0);
            S_EXI:     return v(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 0, 0, 0);
            S_LUI:     return v(0, 0, 0, 0, 2'b00, 2'b00, 2'b01, 3'b101, 0, 0, 0);
            S_AUIPC:   return v(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b100, 0, 0, 0);
            S_WB:      return v(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 1, 1, 0);
            S_BEQ:     return v(z, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b011, 0, 1, 0);
            S_JAL:     return v(1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b001, 0, 0, 0);
            S_JADR:    return v(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b110, 0, 0, 0);
            default:   return v(1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b001, 0, 0, 0);
        endcase
    endfunction

    task automatic load_plan(input logic [6:0] o);
        plan = '{S_FETCH};
        case (o)
            7'b0110011: plan = {plan, S_DEC, S_EXR, S_WB};
            7'b0010011: plan = {plan, S_DEC, S_EXI, S_WB};
            7'b0110111: plan = {plan, S_DEC, S_LUI, S_WB};
            7'b0010111: plan = {plan, S_DEC, S_AUIPC, S_WB};
            7'b0000011: plan = {plan, S_DEC, S_ADR_L, S_RD, S_LWB};
            7'b0100011: plan = {plan, S_DEC, S_ADR_S, S_WR};
            7'b1100011: plan = {plan, S_DEC, S_BEQ};
            7'b1101111: plan = {plan, S_DEC, S_JAL, S_WB};
            7'b1100111: plan = {plan, S_DEC, S_JADR, S_JALR, S_WB};
            default:    plan = {plan, S_DEC_ILL};
        endcase
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    logic [6:0] legal [9] = '{7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111,
                              7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111, 7'b1100111};

    initial begin
        logic [15:0] got, exp;
        step_t       cur;
        bit          holds;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (plan.size() == 0) begin
                if ($urandom_range(0, 9) == 0) begin
                    do op = 7'($urandom); while (op inside {legal});
                end else begin
                    op = legal[$urandom_range(0, 8)];
                end
                load_plan(op);
            end
            zero      = 1'($urandom);
            mem_ready = WAIT_EN ? ($urandom_range(0, 2) != 0) : 1'($urandom);
            rst       = (cyc > 0) && ($urandom_range(0, 49) == 0);
            #1;
            cur   = plan[0];
            holds = WAIT_EN && !mem_ready && (cur inside {S_FETCH, S_RD, S_WR});
            exp   = expect_out(cur, zero, !holds);
            got   = {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
                     alu_src_b, alu_op, reg_write, instr_done, illegal_op};
            check(cur.name(), 32'(got), 32'(exp));
            check("retired", 32'(retired), 32'(model_ret % (1 << CW)));
            if (rst) begin
                plan.delete();
                model_ret = 0;
            end else begin
                if (exp[1]) model_ret++;
                if (!holds) void'(plan.pop_front());
            end
            @(negedge clk);
        end
        rst = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
